// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment scan controller.
//   scan_state_e : DEAD (all enables off) / DRIVE (one digit lit)
//   SEG_BLANK    : segment pattern for a dark digit
//   SEG_GLYPH    : hex glyph table, entry n = {g,f,e,d,c,b,a} for nibble n
package seg7_pkg;

  typedef enum logic {
    DEAD  = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Entry 0 is the rightmost element: 0=3F ... F=71.
  localparam logic [15:0][6:0] SEG_GLYPH = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h67, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex-to-7-segment glyph lookup.
//   nib     in  4  hex digit value
//   glyph_c out 7  segments {g,f,e,d,c,b,a}, active high
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] glyph_c
);

  assign glyph_c = SEG_GLYPH[nib];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed N-digit 7-segment scan controller with dead time between
// digits and a frame-aligned valid/ready load buffer.
//   clk, rst_n   clock, async active-low reset
//   load_valid   new display value offered
//   load_ready   pending buffer free (registered)
//   load_data    4*N_DIGITS, nibble i = digit i
//   blank_mask   1 = force digit i dark (live)
//   lz_suppress  1 = blank leading zero digits (live)
//   seg          segments {g,f,e,d,c,b,a}, registered
//   an           one-hot digit enable, registered
//   frame_done   1-cycle pulse after the last slot of a frame
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned N_DIGITS    = 4,
  parameter int unsigned DIV_WIDTH   = 16,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned DEAD_CYC    = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*N_DIGITS-1:0]   load_data,
  input  logic [N_DIGITS-1:0]     blank_mask,
  input  logic                    lz_suppress,
  output logic [6:0]              seg,
  output logic [N_DIGITS-1:0]     an,
  output logic                    frame_done
);

  localparam int unsigned IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned DATA_W = 4 * N_DIGITS;

  localparam logic [DIV_WIDTH-1:0] CNT_LAST = DIV_WIDTH'(REFRESH_DIV - 1);
  localparam logic [DIV_WIDTH-1:0] CNT_DEAD = DIV_WIDTH'(DEAD_CYC);
  localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(N_DIGITS - 1);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  scan_state_e          state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0]    act_q, act_d;
  logic [DATA_W-1:0]    pend_q, pend_d;
  logic                 pend_full_q, pend_full_d;
  logic                 load_ready_q, load_ready_d;
  logic [6:0]           seg_q, seg_d;
  logic [N_DIGITS-1:0]  an_q, an_d;
  logic                 frame_done_q, frame_done_d;

  logic                 tick;
  logic                 boundary;
  logic                 accept;
  logic [3:0]           nib;
  logic [6:0]           glyph_c;
  logic [N_DIGITS-1:0]  upper_zero;
  logic                 digit_dark;
  logic                 lit;

  assign nib = act_q[{idx_q, 2'b00} +: 4];

  seg7_hex_decoder u_dec (
    .nib     (nib),
    .glyph_c (glyph_c)
  );

  // upper_zero[i]: nibbles i..N_DIGITS-1 of the active value are all zero.
  always_comb begin
    upper_zero = '0;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      upper_zero[i] = ((act_q >> (4 * i)) == '0);
    end
  end

  // Next-state: prescaler, scan FSM, digit index, load buffer and outputs.
  always_comb begin
    cnt_d        = cnt_q;
    state_d      = state_q;
    idx_d        = idx_q;
    act_d        = act_q;
    pend_d       = pend_q;
    pend_full_d  = pend_full_q;
    load_ready_d = load_ready_q;
    seg_d        = SEG_BLANK;
    an_d         = '0;
    frame_done_d = 1'b0;

    tick     = (cnt_q == CNT_LAST);
    boundary = tick && (idx_q == IDX_LAST);
    accept   = load_valid && load_ready_q;

    cnt_d = tick ? '0 : cnt_q + DIV_WIDTH'(1);

    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end

    // DEAD is left once the next count reaches the dead-time length.
    case (state_q)
      DEAD: begin
        if ((DEAD_CYC == 0) || (cnt_d == CNT_DEAD)) state_d = DRIVE;
      end
      DRIVE: begin
        if (tick) state_d = (DEAD_CYC == 0) ? DRIVE : DEAD;
      end
      default: state_d = DEAD;
    endcase

    // Apply pending first so a same-cycle accept refills the buffer.
    if (boundary && pend_full_q) begin
      act_d       = pend_q;
      pend_full_d = 1'b0;
    end
    if (accept) begin
      pend_d      = load_data;
      pend_full_d = 1'b1;
    end
    load_ready_d = !pend_full_d;
    frame_done_d = boundary;

    // Digit 0 is never leading-zero suppressed.
    digit_dark = blank_mask[idx_q] ||
                 (lz_suppress && (idx_q != '0) && upper_zero[idx_q]);
    lit        = (state_q == DRIVE) && !digit_dark;
    if (lit) begin
      seg_d = glyph_c;
      an_d  = N_DIGITS'(1) << idx_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      state_q      <= DEAD;
      idx_q        <= '0;
      act_q        <= '0;
      pend_q       <= '0;
      pend_full_q  <= 1'b0;
      load_ready_q <= 1'b1;
      seg_q        <= SEG_BLANK;
      an_q         <= '0;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      idx_q        <= idx_d;
      act_q        <= act_d;
      pend_q       <= pend_d;
      pend_full_q  <= pend_full_d;
      load_ready_q <= load_ready_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign load_ready = load_ready_q;
  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl (N_DIGITS=4, REFRESH_DIV=8, DEAD_CYC=2).
// Expected frames are queued when a load is driven and popped when the DUT
// scans the frame that follows a frame_done pulse.
module tb_seg7_scan_ctrl;

  localparam int SLOT = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_data = '0;
  logic [3:0]  blank_mask = '0;
  logic        lz_suppress = 1'b0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .N_DIGITS    (4),
    .DIV_WIDTH   (16),
    .REFRESH_DIV (8),
    .DEAD_CYC    (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_data   (load_data),
    .blank_mask  (blank_mask),
    .lz_suppress (lz_suppress),
    .seg         (seg),
    .an          (an),
    .frame_done  (frame_done)
  );

  typedef struct packed {
    logic [3:0][3:0] an;
    logic [3:0][6:0] seg;
  } frame_t;

  frame_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int fd_cnt  = 0;
  int last_fd = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every frame_done pulse and the cycle it was seen in.
  always @(negedge clk) begin
    if (frame_done) begin
      fd_cnt  = fd_cnt + 1;
      last_fd = cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h3F;  4'h1: glyph = 7'h06;  4'h2: glyph = 7'h5B;  4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;  4'h5: glyph = 7'h6D;  4'h6: glyph = 7'h7D;  4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;  4'h9: glyph = 7'h67;  4'hA: glyph = 7'h77;  4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;  4'hD: glyph = 7'h5E;  4'hE: glyph = 7'h79;  default: glyph = 7'h71;
    endcase
  endfunction

  function automatic frame_t mk_frame(input logic [15:0] v, input logic [3:0] m, input logic l);
    frame_t      f;
    logic [15:0] up;
    logic        dark;
    for (int s = 0; s < 4; s++) begin
      up       = v >> (4 * s);
      dark     = m[s] || (l && (s > 0) && (up == 16'h0000));
      f.an[s]  = dark ? 4'h0 : 4'(1 << s);
      f.seg[s] = dark ? 7'h00 : glyph(v[4*s +: 4]);
    end
    return f;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string tag);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got timeout expected event (cyc %0d)", tag, cyc);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int target);
    if (cyc > target) timeout_fail("wait_cyc_passed");
    while (cyc < target) step();
  endtask

  // Wait until more than ref_cnt frame_done pulses were seen; fs = its cycle.
  task automatic wait_fd(input int ref_cnt, output int fs);
    int lim = 0;
    while (fd_cnt <= ref_cnt && lim < 200) begin
      step();
      lim++;
    end
    if (fd_cnt <= ref_cnt) timeout_fail("frame_done_wait");
    fs = last_fd;
  endtask

  task automatic push_exp(input logic [15:0] v);
    exp_q.push_back(mk_frame(v, blank_mask, lz_suppress));
  endtask

  task automatic do_load(input logic [15:0] v);
    int lim = 0;
    while (!load_ready && lim < 100) begin
      step();
      lim++;
    end
    if (!load_ready) timeout_fail("load_ready_wait");
    load_valid = 1'b1;
    load_data  = v;
    step();
    load_valid = 1'b0;
    chk("ready_drop", 32'(load_ready), 32'h0);
  endtask

  // Slot s: dead sample at count 2, driven sample at count 5.
  task automatic check_frame(input int fs);
    frame_t f;
    if (exp_q.size() == 0) begin
      timeout_fail("scoreboard_empty");
      return;
    end
    f = exp_q.pop_front();
    for (int s = 0; s < 4; s++) begin
      wait_cyc(fs + SLOT * s + 2);
      chk($sformatf("dead_an_s%0d", s), 32'(an), 32'h0);
      chk($sformatf("dead_seg_s%0d", s), 32'(seg), 32'h0);
      wait_cyc(fs + SLOT * s + 5);
      chk($sformatf("an_s%0d", s), 32'(an), 32'(f.an[s]));
      chk($sformatf("seg_s%0d", s), 32'(seg), 32'(f.seg[s]));
    end
  endtask

  initial begin
    int fs, fs2, a, b, fdr;

    // Reset values
    repeat (3) step();
    chk("rst_seg", 32'(seg), 32'h0);
    chk("rst_an", 32'(an), 32'h0);
    chk("rst_frame_done", 32'(frame_done), 32'h0);
    chk("rst_load_ready", 32'(load_ready), 32'h1);
    rst_n = 1'b1;
    step();

    // 1: basic load and scan
    do_load(16'h12AF);
    push_exp(16'h12AF);
    wait_fd(fd_cnt, fs);
    check_frame(fs);

    // 2: leading-zero suppression
    lz_suppress = 1'b1;
    do_load(16'h0042);
    push_exp(16'h0042);
    wait_fd(fd_cnt, fs);
    check_frame(fs);
    do_load(16'h0000);
    push_exp(16'h0000);
    wait_fd(fd_cnt, fs);
    check_frame(fs);

    // 3: offer a load on the boundary tick while pending is full
    lz_suppress = 1'b0;
    wait_fd(fd_cnt, fs);
    do_load(16'h3456);
    wait_cyc(fs + 31);
    chk("ready_full_at_tick", 32'(load_ready), 32'h0);
    fdr        = fd_cnt;
    load_valid = 1'b1;
    load_data  = 16'h789A;
    do_load(16'h789A);
    push_exp(16'h3456);
    push_exp(16'h789A);
    wait_fd(fdr, fs2);
    check_frame(fs2);
    chk("ready_low_between", 32'(load_ready), 32'h0);
    wait_fd(fd_cnt, fs);
    check_frame(fs);

    // 4: data changing while load_ready is low must be ignored
    wait_fd(fd_cnt, fs);
    do_load(16'hBCDE);
    load_valid = 1'b1;
    while (cyc < fs + 29) begin
      load_data = 16'($urandom);
      step();
    end
    chk("ready_low_spam", 32'(load_ready), 32'h0);
    load_valid = 1'b0;
    push_exp(16'hBCDE);
    wait_fd(fd_cnt, fs);
    check_frame(fs);

    // 5: blank mask and frame period
    blank_mask = 4'b0100;
    push_exp(16'hBCDE);
    wait_fd(fd_cnt, a);
    check_frame(a);
    push_exp(16'hBCDE);
    wait_fd(fd_cnt, b);
    chk("fd_period", 32'(b - a), 32'd32);
    check_frame(b);

    // 6: reset mid-DRIVE with a pending load
    blank_mask  = 4'b0000;
    lz_suppress = 1'b1;
    wait_fd(fd_cnt, fs);
    do_load(16'h5555);
    wait_cyc(fs + SLOT + 4);
    chk("pre_rst_an", 32'(an), 32'h2);
    chk("pre_rst_seg", 32'(seg), 32'h5E);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_seg", 32'(seg), 32'h0);
    chk("mid_rst_an", 32'(an), 32'h0);
    chk("mid_rst_ready", 32'(load_ready), 32'h1);
    chk("mid_rst_fd", 32'(frame_done), 32'h0);
    step();
    step();
    rst_n = 1'b1;
    push_exp(16'h0000);
    wait_fd(fd_cnt, fs);
    check_frame(fs);
    push_exp(16'h0000);
    wait_fd(fd_cnt, fs);
    check_frame(fs);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
